// File: rtl/fold_sequencer_if.sv
// Handshake bundle between the fold sequencer, the upstream tile buffer and the PE array.
interface fold_sequencer_if #(
  parameter int unsigned LOG_FOLD = 2
);
  logic                in_valid;
  logic                in_ready;
  logic                load_en;
  logic [LOG_FOLD-1:0] select;
  logic                out_valid;
  logic                out_ready;
  logic [LOG_FOLD-1:0] out_idx;
  logic                out_last;
  logic                tile_done;
  logic                busy;

  modport master (
    input  in_valid, out_ready,
    output in_ready, load_en, select, out_valid, out_idx, out_last, tile_done, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, load_en, select, out_valid, out_idx, out_last, tile_done, busy
  );
endinterface

// File: rtl/fold_sequencer.sv
// Steps the fold-mux slice select through one tile and emits delay-matched beats to the PE array.
// Optional FOLD_PERF_EN adds saturating tile/stall counters.
module fold_sequencer #(
  parameter int unsigned FOLD     = 4,
  parameter int unsigned LOG_FOLD = 2,
  parameter int unsigned DATA_LAT = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef FOLD_PERF_EN
  output logic [31:0] perf_tiles,
  output logic [31:0] perf_stalls,
`endif
  fold_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [LOG_FOLD-1:0] LAST_SEL = LOG_FOLD'(FOLD - 1);

  state_t              state, state_nxt;
  logic [LOG_FOLD-1:0] sel_q, sel_nxt;
  logic                cand, cand_last, stall, issue;
  logic                ov, ol;
  logic [LOG_FOLD-1:0] oi;

  // A candidate slice is presented every ISSUE cycle; it counts as issued only when not stalled.
  assign cand      = (state == ISSUE);
  assign cand_last = (sel_q == LAST_SEL);
  assign stall     = ov & ~bus.out_ready;
  assign issue     = cand & ~stall;

  assign bus.in_ready  = (state == IDLE);
  assign bus.load_en   = bus.in_valid & (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.select    = sel_q;
  assign bus.out_valid = ov;
  assign bus.out_idx   = oi;
  assign bus.out_last  = ol;
  assign bus.tile_done = ov & bus.out_ready & ol;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
    end else if (!stall) begin
      state <= state_nxt;
      sel_q <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    case (state)
      IDLE: begin
        if (bus.load_en) begin
          state_nxt = ISSUE;
          sel_nxt   = '0;
        end
      end
      ISSUE: begin
        if (issue) begin
          sel_nxt = cand_last ? '0 : sel_q + 1'b1;
          // With no pipe the final beat is accepted in the issue cycle itself.
          if (cand_last) state_nxt = (DATA_LAT == 0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (bus.tile_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  if (DATA_LAT == 0) begin : g_nopipe
    assign ov = cand;
    assign oi = sel_q;
    assign ol = cand & cand_last;
  end else begin : g_pipe
    logic                pv [DATA_LAT];
    logic                pl [DATA_LAT];
    logic [LOG_FOLD-1:0] pi [DATA_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DATA_LAT; i++) begin
          pv[i] <= 1'b0;
          pl[i] <= 1'b0;
          pi[i] <= '0;
        end
      end else if (!stall) begin
        pv[0] <= cand;
        pi[0] <= cand ? sel_q : '0;
        pl[0] <= cand & cand_last;
        for (int unsigned i = 1; i < DATA_LAT; i++) begin
          pv[i] <= pv[i-1];
          pi[i] <= pi[i-1];
          pl[i] <= pl[i-1];
        end
      end
    end

    assign ov = pv[DATA_LAT-1];
    assign oi = pi[DATA_LAT-1];
    assign ol = pl[DATA_LAT-1];
  end

`ifdef FOLD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_tiles  <= '0;
      perf_stalls <= '0;
    end else begin
      if (bus.tile_done && perf_tiles != '1) perf_tiles <= perf_tiles + 32'd1;
      if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fold_sequencer.sv
// Bench for fold_sequencer: directed vector table on DATA_LAT=1, random run of DATA_LAT=1 and 0 against a progress model.
module tb_fold_sequencer;
  localparam int FOLD     = 4;
  localparam int LOG_FOLD = 2;
  localparam int LAT1     = 1;
  localparam int LAT0     = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fold_sequencer_if #(.LOG_FOLD(LOG_FOLD)) b1 ();
  fold_sequencer_if #(.LOG_FOLD(LOG_FOLD)) b0 ();

`ifdef FOLD_PERF_EN
  logic [31:0] pt1, ps1, pt0, ps0;
`endif

  fold_sequencer #(.FOLD(FOLD), .LOG_FOLD(LOG_FOLD), .DATA_LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef FOLD_PERF_EN
    .perf_tiles(pt1), .perf_stalls(ps1),
`endif
    .bus(b1)
  );

  fold_sequencer #(.FOLD(FOLD), .LOG_FOLD(LOG_FOLD), .DATA_LAT(LAT0)) dut0 (
    .clk(clk), .rst(rst),
`ifdef FOLD_PERF_EN
    .perf_tiles(pt0), .perf_stalls(ps0),
`endif
    .bus(b0)
  );

  int tests  = 0;
  int failed = 0;

  // Output word: {in_ready, load_en, select[1:0], out_valid, out_idx[1:0], out_last, tile_done, busy}
  typedef struct packed {
    logic       r;
    logic       iv;
    logic       ordy;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic o, logic ir, logic le, int sel,
                              logic ov, int idx, logic last, logic done, logic busy);
    vec_t v;
    v.r    = r;
    v.iv   = iv;
    v.ordy = o;
    v.exp  = {ir, le, 2'(sel), ov, 2'(idx), last, done, busy};
    return v;
  endfunction

  function automatic logic [9:0] snap1();
    return {b1.in_ready, b1.load_en, b1.select, b1.out_valid, b1.out_idx,
            b1.out_last, b1.tile_done, b1.busy};
  endfunction

  function automatic logic [9:0] snap0();
    return {b0.in_ready, b0.load_en, b0.select, b0.out_valid, b0.out_idx,
            b0.out_last, b0.tile_done, b0.busy};
  endfunction

  // Progress model: v counts unstalled cycles since the load handshake (0 = idle).
  function automatic logic [9:0] model_out(int v, int lat, logic iv, logic ordy);
    logic       ir, le, ov, last, done, busy;
    logic [1:0] sel, idx;
    ir   = (v == 0);
    le   = ir & iv;
    busy = !ir;
    sel  = (v >= 1 && v <= FOLD) ? 2'(v - 1) : 2'd0;
    ov   = (v >= 1 + lat) && (v <= FOLD + lat);
    idx  = ov ? 2'(v - 1 - lat) : 2'd0;
    last = ov && (idx == 2'(FOLD - 1));
    done = last & ordy;
    return {ir, le, sel, ov, idx, last, done, busy};
  endfunction

  function automatic int next_v(int v, int lat, logic r, logic iv, logic stall);
    if (r) return 0;
    if (v == 0) return iv ? 1 : 0;
    if (stall) return v;
    if (v + 1 > FOLD + lat) return 0;
    return v + 1;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic iv, logic o);
    rst          = r;
    b1.in_valid  = iv;
    b0.in_valid  = iv;
    b1.out_ready = o;
    b0.out_ready = o;
  endtask

  initial begin
    logic [9:0] e1, e0;
    int         v1, v0, mt1, ms1, mt0, ms0;
    logic       r, iv, o;

    drive(1'b1, 1'b0, 1'b1);

    // reset held two cycles
    vecs.push_back(mk(1,0,1, 1,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,1, 1,0,0,0,0,0,0,0));
    // single tile, no stall
    vecs.push_back(mk(0,1,1, 1,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,1,1,0,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,2,1,1,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,3,1,2,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,0,1,3,1,1,1));
    vecs.push_back(mk(0,0,1, 1,0,0,0,0,0,0,0));
    // backpressure cycles 3..5, in_valid while busy ignored
    vecs.push_back(mk(0,1,1, 1,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,1,1,0,0,0,1));
    vecs.push_back(mk(0,1,0, 0,0,2,1,1,0,0,1));
    vecs.push_back(mk(0,1,0, 0,0,2,1,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,2,1,1,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,2,1,1,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,3,1,2,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,0,1,3,1,1,1));
    vecs.push_back(mk(0,0,1, 1,0,0,0,0,0,0,0));
    // reset at cycle 3 mid-tile, then a clean tile from select 0
    vecs.push_back(mk(0,1,1, 1,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,1,1,0,0,0,1));
    vecs.push_back(mk(1,0,1, 0,0,2,1,1,0,0,1));
    vecs.push_back(mk(0,0,1, 1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1, 1,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,1,1,0,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,2,1,1,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,3,1,2,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,0,1,3,1,1,1));
    vecs.push_back(mk(0,0,1, 1,0,0,0,0,0,0,0));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].r, vecs[i].iv, vecs[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(snap1()), 32'(vecs[i].exp));
    end

    // back-to-back tiles with in_valid held: a load every FOLD+DATA_LAT+1 cycles
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check($sformatf("b2b%0d", c), {30'd0, b1.load_en, b1.busy},
            {30'd0, (c % 6) == 0, (c % 6) != 0});
    end

    // random run of both latencies against the progress model
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1);
    v1 = 0; v0 = 0; mt1 = 0; ms1 = 0; mt0 = 0; ms0 = 0;
`ifdef FOLD_PERF_EN
    @(negedge clk);
    @(posedge clk); #1;
    check("perf_reset", {pt1[15:0], ps1[15:0]}, 32'd0);
    @(negedge clk);
`endif
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      r  = ($urandom_range(0, 79) == 0);
      iv = 1'($urandom_range(0, 1));
      o  = ($urandom_range(0, 9) < 7);
      drive(r, iv, o);
      @(negedge clk);
      e1 = model_out(v1, LAT1, iv, o);
      e0 = model_out(v0, LAT0, iv, o);
      check($sformatf("rand_l1_%0d", n), 32'(snap1()), 32'(e1));
      check($sformatf("rand_l0_%0d", n), 32'(snap0()), 32'(e0));
      mt1 = r ? 0 : mt1 + int'(e1[1]);
      ms1 = r ? 0 : ms1 + int'(e1[5] & ~o);
      mt0 = r ? 0 : mt0 + int'(e0[1]);
      ms0 = r ? 0 : ms0 + int'(e0[5] & ~o);
      v1 = next_v(v1, LAT1, r, iv, e1[5] & ~o);
      v0 = next_v(v0, LAT0, r, iv, e0[5] & ~o);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1);
`ifdef FOLD_PERF_EN
    check("perf_tiles_l1",  pt1, 32'(mt1));
    check("perf_stalls_l1", ps1, 32'(ms1));
    check("perf_tiles_l0",  pt0, 32'(mt0));
    check("perf_stalls_l0", ps0, 32'(ms0));

    // three tiles with five injected stall cycles
    begin
      int loads, tiles, inj;
      logic stall_now;
      loads = 0; tiles = 0; inj = 0;
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b1);
      for (int n = 0; n < 300 && tiles < 3; n++) begin
        @(posedge clk); #1;
        stall_now = b1.out_valid && inj < 5 && (n % 2 == 1);
        if (stall_now) inj++;
        drive(1'b0, loads < 3, !stall_now);
        @(negedge clk);
        if (b1.load_en) loads++;
        if (b1.tile_done) tiles++;
      end
      check("perf_seq_tiles_seen", 32'(tiles), 32'd3);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1);
      check("perf_seq_tiles",  pt1, 32'd3);
      check("perf_seq_stalls", ps1, 32'd5);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
